// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
//   Pipeline bundle between the EX/MEM register, the MEM stage and the
//   MEM/WB register. It carries everything except clock, reset, the
//   Clr/Ld controls and the misaligned-access status.
//
//   MEM_* : EX/MEM register outputs consumed by the MEM stage
//   WB_*  : registered write-back bundle handed to the WB mux
//   BranchTaken : combinational branch resolution in MEM
//
//   master : the side that drives MEM_* (EX/MEM register, or a testbench)
//   slave  : the MEM stage itself (mem_wb_stage)
// ---------------------------------------------------------------------------
interface mem_wb_stage_if;
    logic        MEM_RegWrite;
    logic        MEM_MemtoReg;
    logic        MEM_Branch;
    logic        MEM_Zero;
    logic        MEM_MemWrite;
    logic        MEM_MemRead;
    logic [1:0]  MEM_Datatype;
    logic [31:0] MEM_ALUResult;
    logic [31:0] MEM_Data2;
    logic [4:0]  MEM_RegDstData;

    logic        BranchTaken;
    logic        WB_RegWrite;
    logic        WB_MemtoReg;
    logic [31:0] WB_ReadData;
    logic [31:0] WB_ALUResult;
    logic [4:0]  WB_RegDstData;

    modport master (
        output MEM_RegWrite, MEM_MemtoReg, MEM_Branch, MEM_Zero,
               MEM_MemWrite, MEM_MemRead, MEM_Datatype, MEM_ALUResult,
               MEM_Data2, MEM_RegDstData,
        input  BranchTaken, WB_RegWrite, WB_MemtoReg, WB_ReadData,
               WB_ALUResult, WB_RegDstData
    );

    modport slave (
        input  MEM_RegWrite, MEM_MemtoReg, MEM_Branch, MEM_Zero,
               MEM_MemWrite, MEM_MemRead, MEM_Datatype, MEM_ALUResult,
               MEM_Data2, MEM_RegDstData,
        output BranchTaken, WB_RegWrite, WB_MemtoReg, WB_ReadData,
               WB_ALUResult, WB_RegDstData
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM pipeline stage plus MEM/WB pipeline register. Performs byte/half/word
//   loads and stores on a local data memory, resolves branch-taken, flags
//   misaligned accesses and keeps a saturating count of them.
//
// Parameters
//   ADDR_W : word-address width, memory depth = 2**ADDR_W 32-bit words
//   ERR_W  : width of the misaligned-access counter
//
// Ports
//   Clk           in   rising-edge clock
//   Rst           in   asynchronous active-high reset
//   Clr           in   synchronous flush of the MEM/WB register (bubble)
//   Ld            in   load enable; 0 = stall (hold register, block store)
//   bus           slave modport of mem_wb_stage_if (MEM_* in, WB_* out)
//   MisalignErr   out  access in the last latched cycle was misaligned
//   MisalignCount out  saturating count of misaligned accesses
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int ADDR_W = 10,
    parameter int ERR_W  = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Clr,
    input  logic               Ld,
    mem_wb_stage_if.slave      bus,
    output logic               MisalignErr,
    output logic [ERR_W-1:0]   MisalignCount
);

    // Encoding 11 behaves exactly like a word access.
    typedef enum logic [1:0] {
        DT_WORD     = 2'b00,
        DT_HALF     = 2'b01,
        DT_BYTE     = 2'b10,
        DT_WORD_ALT = 2'b11
    } datatype_e;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    datatype_e         dtype;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic [31:0]       rd_word;

    logic        misalign_cond;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [31:0] rd_ext;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;

    logic        misaligned;
    logic        latch_en;
    logic        store_en;
    logic        load_ok;

    assign dtype    = datatype_e'(bus.MEM_Datatype);
    assign word_idx = bus.MEM_ALUResult[ADDR_W+1:2];
    assign byte_off = bus.MEM_ALUResult[1:0];
    assign rd_word  = mem[word_idx];

    // Lane selection, store replication and load extension per access size.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        misalign_cond = 1'b0;
        byte_en       = 4'hF;
        wr_data       = bus.MEM_Data2;
        rd_ext        = rd_word;
        rd_half       = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte       = 8'(rd_word >> {byte_off, 3'b000});
        case (dtype)
            DT_HALF: begin
                misalign_cond = byte_off[0];
                byte_en       = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_data       = {2{bus.MEM_Data2[15:0]}};
                rd_ext        = {{16{rd_half[15]}}, rd_half};
            end
            DT_BYTE: begin
                byte_en       = 4'b0001 << byte_off;
                wr_data       = {4{bus.MEM_Data2[7:0]}};
                rd_ext        = {{24{rd_byte[7]}}, rd_byte};
            end
            default: begin
                misalign_cond = |byte_off;
            end
        endcase
    end

    assign misaligned = (bus.MEM_MemRead | bus.MEM_MemWrite) & misalign_cond;
    assign latch_en   = Ld & ~Clr;
    assign store_en   = ~Rst & latch_en & bus.MEM_MemWrite & ~misaligned;
    // Load data only for a pure, aligned read; a read-with-store returns 0.
    assign load_ok    = bus.MEM_MemRead & ~bus.MEM_MemWrite & ~misaligned;

    assign bus.BranchTaken = bus.MEM_Branch & bus.MEM_Zero;

    // NOTE: the data memory has no reset; clearing it would force a
    // register-based implementation instead of a RAM.
    always_ff @(posedge Clk) begin
        if (store_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // MEM/WB register and misalignment status. Priority: Rst > Clr > Ld.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bus.WB_RegWrite   <= 1'b0;
            bus.WB_MemtoReg   <= 1'b0;
            bus.WB_ReadData   <= '0;
            bus.WB_ALUResult  <= '0;
            bus.WB_RegDstData <= '0;
            MisalignErr       <= 1'b0;
            MisalignCount     <= '0;
        end else if (Clr) begin
            bus.WB_RegWrite   <= 1'b0;
            bus.WB_MemtoReg   <= 1'b0;
            bus.WB_ReadData   <= '0;
            bus.WB_ALUResult  <= '0;
            bus.WB_RegDstData <= '0;
            MisalignErr       <= 1'b0;
        end else if (Ld) begin
            // A misaligned load must not write the register file.
            bus.WB_RegWrite   <= bus.MEM_RegWrite & ~(bus.MEM_MemRead & misaligned);
            bus.WB_MemtoReg   <= bus.MEM_MemtoReg;
            bus.WB_ReadData   <= load_ok ? rd_ext : 32'h0;
            bus.WB_ALUResult  <= bus.MEM_ALUResult;
            bus.WB_RegDstData <= bus.MEM_RegDstData;
            MisalignErr       <= misaligned;
            if (misaligned && (MisalignCount != {ERR_W{1'b1}})) begin
                MisalignCount <= MisalignCount + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed self-checking bench for mem_wb_stage with hand-computed
//   expected values. Inputs change one time unit after a rising edge and
//   outputs are sampled at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Clr = 1'b0;
    logic       Ld  = 1'b1;
    logic       MisalignErr;
    logic [7:0] MisalignCount;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.ADDR_W(10), .ERR_W(8)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Clr           (Clr),
        .Ld            (Ld),
        .bus           (bus),
        .MisalignErr   (MisalignErr),
        .MisalignCount (MisalignCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] dt,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic regwr, input logic m2r);
        bus.MEM_MemWrite   = we;
        bus.MEM_MemRead    = re;
        bus.MEM_Datatype   = dt;
        bus.MEM_ALUResult  = addr;
        bus.MEM_Data2      = data;
        bus.MEM_RegDstData = rd;
        bus.MEM_RegWrite   = regwr;
        bus.MEM_MemtoReg   = m2r;
    endtask

    task automatic op_store(input logic [1:0] dt, input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b0, dt, addr, data, 5'd0, 1'b0, 1'b0);
        step();
    endtask

    task automatic op_load(input logic [1:0] dt, input logic [31:0] addr, input logic [4:0] rd);
        drive(1'b0, 1'b1, dt, addr, 32'h0, rd, 1'b1, 1'b1);
        step();
    endtask

    initial begin
        bus.MEM_Branch = 1'b0;
        bus.MEM_Zero   = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

        // Reset state
        step();
        step();
        check("rst_regwrite", {31'b0, bus.WB_RegWrite}, 32'h0);
        check("rst_readdata", bus.WB_ReadData, 32'h0);
        check("rst_count",    {24'b0, MisalignCount}, 32'h0);
        Rst = 1'b0;

        // Store word then load it back on the next cycle
        op_store(2'b00, 32'h10, 32'hDEADBEEF);
        check("sw_readdata_zero", bus.WB_ReadData, 32'h0);
        op_load(2'b00, 32'h10, 5'd4);
        check("lw_deadbeef",  bus.WB_ReadData, 32'hDEADBEEF);
        check("lw_memtoreg",  {31'b0, bus.WB_MemtoReg}, 32'h1);
        check("lw_regwrite",  {31'b0, bus.WB_RegWrite}, 32'h1);
        check("lw_regdst",    {27'b0, bus.WB_RegDstData}, 32'h4);
        // Upper address bits beyond the word index are ignored
        op_load(2'b00, 32'h0000_1010, 5'd5);
        check("lw_alias",     bus.WB_ReadData, 32'hDEADBEEF);
        check("lw_alias_alu", bus.WB_ALUResult, 32'h0000_1010);

        // Byte store into one lane, signed byte/half loads
        op_store(2'b00, 32'h10, 32'h11223344);
        op_store(2'b10, 32'h13, 32'hABCDEF80);
        op_load(2'b10, 32'h13, 5'd6);
        check("lb_13",  bus.WB_ReadData, 32'hFFFFFF80);
        op_load(2'b00, 32'h10, 5'd6);
        check("lw_10",  bus.WB_ReadData, 32'h80223344);
        op_load(2'b10, 32'h10, 5'd6);
        check("lb_10",  bus.WB_ReadData, 32'h00000044);
        op_load(2'b10, 32'h11, 5'd6);
        check("lb_11",  bus.WB_ReadData, 32'h00000033);
        op_load(2'b01, 32'h12, 5'd6);
        check("lh_12",  bus.WB_ReadData, 32'hFFFF8022);

        // Misaligned half store leaves memory intact
        op_store(2'b00, 32'h20, 32'h12345678);
        op_store(2'b01, 32'h21, 32'h00008000);
        check("sh21_err",   {31'b0, MisalignErr}, 32'h1);
        check("sh21_count", {24'b0, MisalignCount}, 32'h1);
        op_load(2'b00, 32'h20, 5'd2);
        check("lw20_unchanged", bus.WB_ReadData, 32'h12345678);
        check("lw20_err",       {31'b0, MisalignErr}, 32'h0);
        op_store(2'b01, 32'h22, 32'hFFFF8000);
        op_load(2'b01, 32'h22, 5'd2);
        check("lh_22",   bus.WB_ReadData, 32'hFFFF8000);
        op_load(2'b11, 32'h20, 5'd2);
        check("lw11_20", bus.WB_ReadData, 32'h80005678);
        op_load(2'b01, 32'h20, 5'd2);
        check("lh_20",   bus.WB_ReadData, 32'h00005678);
        // Misaligned load suppresses write-back, other fields latch
        op_load(2'b00, 32'h22, 5'd3);
        check("mlw_regwrite", {31'b0, bus.WB_RegWrite}, 32'h0);
        check("mlw_readdata", bus.WB_ReadData, 32'h0);
        check("mlw_alu",      bus.WB_ALUResult, 32'h22);
        check("mlw_regdst",   {27'b0, bus.WB_RegDstData}, 32'h3);
        check("mlw_count",    {24'b0, MisalignCount}, 32'h2);

        // Read and write together: store happens, read data is zero
        drive(1'b1, 1'b1, 2'b00, 32'h40, 32'h55, 5'd1, 1'b1, 1'b1);
        step();
        check("rw_readdata", bus.WB_ReadData, 32'h0);
        op_load(2'b00, 32'h40, 5'd1);
        check("rw_stored",   bus.WB_ReadData, 32'h55);

        // Stall blocks the store and holds the register
        op_store(2'b00, 32'h30, 32'hCAFEF00D);
        op_load(2'b00, 32'h30, 5'd7);
        Ld = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 32'h30, 32'h0, 5'd9, 1'b0, 1'b0);
        step();
        check("stall_readdata", bus.WB_ReadData, 32'hCAFEF00D);
        check("stall_regdst",   {27'b0, bus.WB_RegDstData}, 32'h7);
        check("stall_regwrite", {31'b0, bus.WB_RegWrite}, 32'h1);
        drive(1'b0, 1'b1, 2'b00, 32'h31, 32'h0, 5'd9, 1'b1, 1'b1);
        step();
        check("stall_count",    {24'b0, MisalignCount}, 32'h2);
        Ld = 1'b1;
        op_load(2'b00, 32'h30, 5'd8);
        check("stall_nowrite",  bus.WB_ReadData, 32'hCAFEF00D);
        // Flush gives a bubble and blocks stores; counter holds
        Clr = 1'b1;
        op_load(2'b00, 32'h30, 5'd8);
        check("clr_regwrite",   {31'b0, bus.WB_RegWrite}, 32'h0);
        check("clr_readdata",   bus.WB_ReadData, 32'h0);
        check("clr_alu",        bus.WB_ALUResult, 32'h0);
        op_store(2'b00, 32'h30, 32'h1);
        op_load(2'b00, 32'h33, 5'd8);
        check("clr_err",        {31'b0, MisalignErr}, 32'h0);
        check("clr_count",      {24'b0, MisalignCount}, 32'h2);
        Clr = 1'b0;
        op_load(2'b00, 32'h30, 5'd8);
        check("clr_nowrite",    bus.WB_ReadData, 32'hCAFEF00D);

        // Counter saturates at all-ones
        exp_cnt = 2;
        for (int i = 0; i < 300; i++) begin
            op_load(2'b00, 32'h41, 5'd1);
            if (exp_cnt < 255) exp_cnt++;
            if (i == 100) check("sat_mid", {24'b0, MisalignCount}, 32'(exp_cnt));
        end
        check("sat_count", {24'b0, MisalignCount}, 32'd255);
        check("sat_err",   {31'b0, MisalignErr}, 32'h1);

        // Branch resolution is combinational
        bus.MEM_Branch = 1'b1;
        bus.MEM_Zero   = 1'b1;
        #1;
        check("branch_taken", {31'b0, bus.BranchTaken}, 32'h1);
        bus.MEM_Zero = 1'b0;
        #1;
        check("branch_nz",    {31'b0, bus.BranchTaken}, 32'h0);
        bus.MEM_Zero = 1'b1;

        // Mid-cycle reset with Ld=1 clears state immediately
        op_load(2'b00, 32'h30, 5'd8);
        check("pre_rst_regwrite", {31'b0, bus.WB_RegWrite}, 32'h1);
        #2;
        Rst = 1'b1;
        #1;
        check("mid_rst_regwrite", {31'b0, bus.WB_RegWrite}, 32'h0);
        check("mid_rst_readdata", bus.WB_ReadData, 32'h0);
        check("mid_rst_regdst",   {27'b0, bus.WB_RegDstData}, 32'h0);
        check("mid_rst_count",    {24'b0, MisalignCount}, 32'h0);
        check("mid_rst_branch",   {31'b0, bus.BranchTaken}, 32'h1);
        #1;
        Rst = 1'b0;
        // Memory survives reset
        op_load(2'b00, 32'h30, 5'd8);
        check("post_rst_mem", bus.WB_ReadData, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
